// File: rtl/tile_spawn_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tile_spawn_scanner                                           |
// | Purpose : Picks a uniformly indexed empty cell on the 2048 board for   |
// |           a new tile. It drives the shared cell selector. Pass 1       |
// |           counts the empty cells. Pass 2 walks the board to the        |
// |           (rnd mod count)-th empty cell and reports its position.      |
// | Ports   : clk, rst_n    - clock, asynchronous active-low reset         |
// |           start, rnd    - search request; rnd latched on accept        |
// |           sel_pos       - position presented to the cell selector      |
// |           sel_val       - cell value for sel_pos (0 = empty)           |
// |           busy, done    - in-progress flag, one-cycle completion pulse |
// |           full, pos     - result, valid with done                      |
// |           empty_cnt     - final empty count (only with the macro)      |
// | Options : define SPAWN_CNT_OUT_EN to add the empty_cnt output.        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tile_spawn_scanner #(
   parameter int CELLS  = 16,
   parameter int CELL_W = 4,
   parameter int POS_W  = 4,
   parameter int RND_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [RND_W-1:0]  rnd,
   output logic [POS_W-1:0]  sel_pos,
   input  logic [CELL_W-1:0] sel_val,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic [POS_W-1:0]  pos
`ifdef SPAWN_CNT_OUT_EN
   ,
   output logic [POS_W:0]    empty_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_PICK  = 2'd2,
      ST_FIND  = 2'd3
   } state_t;

   // Remainder is computed at the wider of the two operand widths.
   localparam int MOD_W = (RND_W > POS_W + 1) ? RND_W : POS_W + 1;

   localparam logic [POS_W-1:0] C_LAST_POS = POS_W'(CELLS - 1);
   localparam logic [POS_W-1:0] C_POS_ONE  = POS_W'(1);
   localparam logic [POS_W:0]   C_CNT_ONE  = (POS_W + 1)'(1);
   localparam logic [MOD_W-1:0] C_MOD_ONE  = MOD_W'(1);

   state_t             state_q, state_d;
   logic [POS_W-1:0]   scan_q, scan_d;
   logic [POS_W:0]     cnt_q, cnt_d;
   logic [MOD_W-1:0]   hit_q, hit_d;
   logic [MOD_W-1:0]   target_q, target_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               full_q, full_d;
`ifdef SPAWN_CNT_OUT_EN
   logic [POS_W:0]     empty_cnt_q, empty_cnt_d;
`endif

   logic               w_cell_empty;
   logic [MOD_W-1:0]   w_rnd_ext;
   logic [MOD_W-1:0]   w_cnt_ext;
   logic [MOD_W-1:0]   w_rem;

   assign w_cell_empty = (sel_val == '0);
   assign w_rnd_ext    = MOD_W'(rnd_q);
   // Divisor forced non-zero so the unused remainder never goes unknown
   // while the count is still zero.
   assign w_cnt_ext    = (cnt_q == '0) ? C_MOD_ONE : MOD_W'(cnt_q);
   assign w_rem        = w_rnd_ext % w_cnt_ext;

   // The selector only sees a live scan index while a pass is walking.
   assign sel_pos = ((state_q == ST_COUNT) || (state_q == ST_FIND)) ? scan_q : '0;

   always_comb begin
      state_d  = state_q;
      scan_d   = scan_q;
      cnt_d    = cnt_q;
      hit_d    = hit_q;
      target_d = target_q;
      rnd_d    = rnd_q;
      pos_d    = pos_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      full_d   = full_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               rnd_d   = rnd;
               scan_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (w_cell_empty) cnt_d = cnt_q + C_CNT_ONE;
            if (scan_q == C_LAST_POS) state_d = ST_PICK;
            else                      scan_d  = scan_q + C_POS_ONE;
         end
         ST_PICK: begin
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               full_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               target_d = w_rem;
               scan_d   = '0;
               hit_d    = '0;
               state_d  = ST_FIND;
            end
         end
         ST_FIND: begin
            if (w_cell_empty && (hit_q == target_q)) begin
               pos_d   = scan_q;
               full_d  = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               if (w_cell_empty) hit_d = hit_q + C_MOD_ONE;
               // Running off the end means the board changed under us.
               if (scan_q == C_LAST_POS) begin
                  done_d  = 1'b1;
                  full_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  scan_d = scan_q + C_POS_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SPAWN_CNT_OUT_EN
   always_comb begin
      empty_cnt_d = empty_cnt_q;
      if (done_d) empty_cnt_d = cnt_q;
   end
   assign empty_cnt = empty_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         scan_q   <= '0;
         cnt_q    <= '0;
         hit_q    <= '0;
         target_q <= '0;
         rnd_q    <= '0;
         pos_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         full_q   <= 1'b0;
`ifdef SPAWN_CNT_OUT_EN
         empty_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         scan_q   <= scan_d;
         cnt_q    <= cnt_d;
         hit_q    <= hit_d;
         target_q <= target_d;
         rnd_q    <= rnd_d;
         pos_q    <= pos_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         full_q   <= full_d;
`ifdef SPAWN_CNT_OUT_EN
         empty_cnt_q <= empty_cnt_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign full = full_q;
   assign pos  = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_spawn_scanner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_tile_spawn_scanner                                        |
// | Purpose : Directed scoreboard bench for tile_spawn_scanner. Stimulus   |
// |           pushes hand-computed results; a monitor pops them on done.   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_tile_spawn_scanner;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  rnd;
   logic [3:0]  sel_pos;
   logic [3:0]  sel_val;
   logic        busy;
   logic        done;
   logic        full;
   logic [3:0]  pos;
`ifdef SPAWN_CNT_OUT_EN
   logic [4:0]  empty_cnt;
`endif

   logic [63:0] board;
   int          cyc;
   int          vectors;
   int          miscompares;
   int          busy_run;

   typedef struct {
      bit       full;
      bit [3:0] pos;
      int       done_at;
      int       lat;
      int       ecnt;
   } exp_t;

   exp_t exp_q[$];

   tile_spawn_scanner dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .rnd     (rnd),
      .sel_pos (sel_pos),
      .sel_val (sel_val),
      .busy    (busy),
      .done    (done),
      .full    (full),
`ifdef SPAWN_CNT_OUT_EN
      .empty_cnt (empty_cnt),
`endif
      .pos     (pos)
   );

   // Behavioural stand-in for the board register plus selector.
   assign sel_val = board[sel_pos*4 +: 4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: consumes one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_full", int'(full), int'(e.full));
               chk("done_pos", int'(pos), int'(e.pos));
               chk("done_cycle", cyc, e.done_at);
               chk("busy_cycles", busy_run, e.lat);
               chk("busy_on_done", int'(busy), 0);
`ifdef SPAWN_CNT_OUT_EN
               chk("empty_cnt", int'(empty_cnt), e.ecnt);
`endif
            end
            busy_run = 0;
         end
         if (busy) busy_run++;
      end
   end

   task automatic push_exp(input int accept, input bit f, input bit [3:0] p,
                           input int lat, input int ecnt);
      exp_t e;
      e.full    = f;
      e.pos     = p;
      e.done_at = accept + lat;
      e.lat     = lat;
      e.ecnt    = ecnt;
      exp_q.push_back(e);
   endtask

   // One-cycle start pulse; lat counts edges from the accepting edge.
   task automatic issue(input logic [63:0] b, input logic [7:0] r, input bit f,
                        input bit [3:0] p, input int lat, input int ecnt);
      @(negedge clk);
      board = b;
      rnd   = r;
      start = 1'b1;
      push_exp(cyc + 1, f, p, lat, ecnt);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_all();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
      if (exp_q.size() != 0) exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   localparam logic [63:0] B_EMPTY = 64'h0000_0000_0000_0000;
   localparam logic [63:0] B_FULL  = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B_ONLY12 = 64'h1110_1111_1111_1111;
   localparam logic [63:0] B_3_7_9 = 64'h1111_1101_0111_0111;

   initial begin
      int a;
      vectors     = 0;
      miscompares = 0;
      busy_run    = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      rnd         = 8'd0;
      board       = B_EMPTY;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_pos", int'(pos), 0);
      chk("rst_sel_pos", int'(sel_pos), 0);
`ifdef SPAWN_CNT_OUT_EN
      chk("rst_empty_cnt", int'(empty_cnt), 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Empty board, rnd=5 -> sixth empty cell is cell 5.
      issue(B_EMPTY, 8'd5, 1'b0, 4'd5, 23, 16);
      wait_all();

      // Full board -> full=1, pos keeps 5.
      issue(B_FULL, 8'd9, 1'b1, 4'd5, 17, 0);
      wait_all();

      // Only cell 12 empty, 200 mod 1 = 0.
      issue(B_ONLY12, 8'd200, 1'b0, 4'd12, 30, 1);
      wait_all();

      // Cells 3,7,9 empty, 4 mod 3 = 1 -> cell 7; rnd changed after accept.
      issue(B_3_7_9, 8'd4, 1'b0, 4'd7, 25, 3);
      rnd = 8'd0;
      wait_all();
      // 5 mod 3 = 2 -> cell 9; 3 mod 3 = 0 -> cell 3.
      issue(B_3_7_9, 8'd5, 1'b0, 4'd9, 27, 3);
      wait_all();
      issue(B_3_7_9, 8'd3, 1'b0, 4'd3, 21, 3);
      wait_all();

      // start held high: first search done at A+20, re-accepted at A+21.
      @(negedge clk);
      board = B_EMPTY;
      rnd   = 8'd2;
      start = 1'b1;
      a     = cyc + 1;
      push_exp(a, 1'b0, 4'd2, 20, 16);
      push_exp(a + 21, 1'b0, 4'd7, 25, 16);
      @(negedge clk);
      rnd = 8'd7;
      repeat (21) @(negedge clk);
      start = 1'b0;
      wait_all();

      // Reset asserted right after edge 8 of a search: no done, outputs 0.
      @(negedge clk);
      board = B_EMPTY;
      rnd   = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_full", int'(full), 0);
      chk("abort_pos", int'(pos), 0);
      chk("abort_sel_pos", int'(sel_pos), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      issue(B_3_7_9, 8'd4, 1'b0, 4'd7, 25, 3);
      wait_all();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
